l3_cache_assoc: RTL and testbench
=================================

Name: l3_cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate shared L3 cache with true-LRU replacement.
- Successor to the direct-mapped L3: geometry is generic in sets, ways and words per line.
- Memory side uses a req/ack handshake with variable latency; saturating hit/miss counters are added.
- Sits between the L2/coherence interconnect (CPU side) and the main-memory model (memory side).

Parameters:
- ADDR_W, 32: byte address width.
- WORD_W, 32: word width; fixed at 32 (byte offset is 2 bits).
- WORDS, 4: words per line, power of 2; LINE_W = WORDS*WORD_W.
- SETS, 64: number of sets, power of 2.
- WAYS, 2: associativity, power of 2, 1..8; WAYS=1 gives a direct-mapped cache.
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-low reset.
- cpu_valid  in  1: request valid.
- cpu_write  in  1: 1 = write, 0 = read.
- cpu_addr  in  ADDR_W: byte address.
- cpu_wdata  in  WORD_W: write word.
- cpu_ready  out  1: cache can accept a request.
- cpu_done  out  1: one-cycle completion pulse.
- cpu_rdata  out  WORD_W: read word; valid only while cpu_done=1, otherwise 0.
- mem_req  out  1: memory request.
- mem_we  out  1: 1 = writeback, 0 = refill.
- mem_addr  out  ADDR_W: line-aligned address.
- mem_wdata  out  LINE_W: victim line.
- mem_rdata  in  LINE_W: refill line, sampled on mem_ack.
- mem_ack  in  1: memory completion, single cycle.
- hit_count  out  CNT_W: hit counter.
- miss_count  out  CNT_W: miss counter.

Behaviour:
- Address split, MSB first: tag = ADDR_W-IDX_W-OFF_W-2 bits | index IDX_W=log2(SETS) | word offset OFF_W=log2(WORDS) | byte offset 2 bits (ignored).
- Word k of a line occupies bits [LINE_W-1-32k -: 32], so word 0 is the most significant word.
- Per-line state: valid, dirty, tag, data, plus a log2(WAYS)-bit age per way per set.
- Reset (reset=0 at a clk edge) completes within that edge and applies regardless of state:
  - State goes to IDLE; all lines become valid=0, dirty=0.
  - Age of way w is set to w in every set.
  - Both counters are cleared; all outputs are 0 except cpu_ready=1.
  - No writeback of dirty data occurs.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE:
  - cpu_ready=1.
  - On cpu_valid, latch addr, write and wdata; go to LOOKUP.
  - mem_ack is ignored.
- LOOKUP: compare the tag against all valid ways of the indexed set.
  - Hit:
    - Assert cpu_done this cycle.
    - Read: cpu_rdata = word at offset.
    - Write: update that word and set dirty=1.
    - Update LRU; go to IDLE.
  - Miss: choose the victim as the lowest-index invalid way, otherwise the way with the maximum age.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to REFILL.
  - Counters: the first LOOKUP of a request increments hit_count or miss_count. The post-refill LOOKUP increments neither. Counters saturate at all-ones.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, zeros}, mem_wdata = victim data.
  - All of these are held stable until mem_ack.
  - On mem_ack: victim dirty=0; go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, zeros}, held until mem_ack.
  - On mem_ack: victim line gets data=mem_rdata, tag=req tag, valid=1, dirty=0; go to LOOKUP, which then hits.
- LRU update on every completing hit:
  - Accessed way age becomes 0.
  - Every way whose age is less than the accessed way's old age increments.
  - Ages in a set always form a permutation of 0..WAYS-1.
- Latency:
  - Hit: cpu_done 1 cycle after acceptance.
  - Clean miss: acceptance, 1 LOOKUP cycle, refill wait until ack, then cpu_done 1 cycle after the ack cycle.
  - Dirty miss: as clean miss, with an extra writeback handshake before the refill.
- Exactly one request is outstanding; cpu_valid while cpu_ready=0 is ignored and not queued.
- mem_req deasserts the cycle after mem_ack unless the next state also requests.

Test Plan (bench: SETS=4, WAYS=2, WORDS=4; index=addr[5:4], tag=addr[31:6]):
1. Cold read 0x10; mem_ack 3 cycles after mem_req, mem_rdata={A0,A1,A2,A3} -> mem_req=1, mem_we=0, mem_addr=0x10; cpu_rdata=0xA0 on cpu_done. Then read 0x1C -> cpu_done 1 cycle after accept, rdata=0xA3, no mem_req; hit_count=1, miss_count=1.
2. After 1, write 0x14 with 0xDEADBEEF -> cpu_done, no mem_req. Read 0x14 -> 0xDEADBEEF; hit_count=3.
3. Read 0x10, read 0x50 (both set 1), read 0x10, read 0x90 -> the 0x90 refill replaces the tag-1 way without writeback; a following read 0x50 misses (mem_addr=0x50) while 0x10 still hits.
4. Write 0x54=0x12345678 after filling 0x50, read 0x10, read 0x90 -> WRITEBACK first with mem_we=1, mem_addr=0x50 and mem_wdata[95:64]=0x12345678; then REFILL with mem_addr=0x90.
5. Hold mem_ack=0 for 20 cycles during REFILL while pulsing cpu_valid -> mem_req, mem_addr and mem_we stay stable, cpu_ready=0, no cpu_done, pulses ignored.
6. Drive reset=0 for 1 cycle mid-REFILL -> next cycle mem_req=0, cpu_ready=1, counters=0; read 0x1C after reset misses.

Source files
------------

// File: rtl/l3_cache_assoc_if.sv
// CPU-side and memory-side handshake bundle for the associative L3.
// The slave modport is the cache's own view of both sides.
interface l3_cache_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
);
    logic              cpu_valid;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [WORD_W-1:0] cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ack,
        output cpu_ready, cpu_done, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ack,
        input  cpu_ready, cpu_done, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l3_cache_assoc.sv
// N-way set-associative write-back/write-allocate L3 with true-LRU ages
// and saturating hit/miss counters.
module l3_cache_assoc #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    l3_cache_assoc_if.slave  bus_if,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int LINE_W = WORDS * WORD_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-3:0]  addr_q;
    logic               write_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [WAY_W-1:0]   victim_q;
    logic               refilled_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic               valid_q [SETS][WAYS];
    logic               dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]  data_q  [SETS][WAYS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic [WAY_W-1:0]   hit_way, victim_c;
    logic [LINE_W-1:0]  hit_line, wr_line;
    logic [WORD_W-1:0]  rd_word;
    logic               unused_addr;

    assign unused_addr = &{1'b0, bus_if.cpu_addr[1:0]};
    assign req_tag     = addr_q[ADDR_W-3 -: TAG_W];
    assign req_idx     = addr_q[OFF_W +: IDX_W];
    assign req_off     = addr_q[0 +: OFF_W];
    assign hit_line    = data_q[req_idx][hit_way];
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest way first, then let the lowest invalid way override it.
    always_comb begin
        victim_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim_c = WAY_W'(w);
        end
    end

    always_comb begin
        rd_word = '0;
        wr_line = hit_line;
        for (int k = 0; k < WORDS; k++) begin
            if (req_off == OFF_W'(k)) begin
                rd_word = hit_line[LINE_W-1-WORD_W*k -: WORD_W];
                wr_line[LINE_W-1-WORD_W*k -: WORD_W] = wdata_q;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        bus_if.cpu_ready = 1'b0;
        bus_if.cpu_done  = 1'b0;
        bus_if.cpu_rdata = '0;
        bus_if.mem_req   = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                bus_if.cpu_ready = 1'b1;
                if (bus_if.cpu_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus_if.cpu_done = 1'b1;
                    if (!write_q) bus_if.cpu_rdata = rd_word;
                    state_d = IDLE;
                end else if (valid_q[req_idx][victim_c] &&
                             dirty_q[req_idx][victim_c]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = REFILL;
                end
            end
            WRITEBACK: begin
                bus_if.mem_req   = 1'b1;
                bus_if.mem_we    = 1'b1;
                bus_if.mem_addr  = {tag_q[req_idx][victim_q], req_idx,
                                    {(OFF_W + 2){1'b0}}};
                bus_if.mem_wdata = data_q[req_idx][victim_q];
                if (bus_if.mem_ack) state_d = REFILL;
            end
            REFILL: begin
                bus_if.mem_req  = 1'b1;
                bus_if.mem_addr = {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                if (bus_if.mem_ack) state_d = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus_if.cpu_valid) begin
                        addr_q     <= bus_if.cpu_addr[ADDR_W-1:2];
                        write_q    <= bus_if.cpu_write;
                        wdata_q    <= bus_if.cpu_wdata;
                        refilled_q <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (!refilled_q) begin
                        if (hit) begin
                            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end else if (miss_cnt_q != '1) begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
                    end
                    if (hit) begin
                        if (write_q) begin
                            data_q[req_idx][hit_way]  <= wr_line;
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                age_q[req_idx][w] <= '0;
                            end else if (age_q[req_idx][w] < age_q[req_idx][hit_way]) begin
                                age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
                            end
                        end
                    end else begin
                        victim_q <= victim_c;
                    end
                end
                WRITEBACK: begin
                    if (bus_if.mem_ack) dirty_q[req_idx][victim_q] <= 1'b0;
                end
                REFILL: begin
                    if (bus_if.mem_ack) begin
                        data_q[req_idx][victim_q]  <= bus_if.mem_rdata;
                        tag_q[req_idx][victim_q]   <= req_tag;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= 1'b0;
                        refilled_q                 <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l3_cache_assoc.sv
// Directed bench for l3_cache_assoc (4 sets, 2 ways, 4 words per line)
// against an ordered-LRU behavioural model and a separate memory image.
module tb_l3_cache_assoc;
    localparam int TW = 2;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] data;
    } memx_t;

    typedef struct {
        bit          w;
        logic [31:0] rd;
    } done_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] hit_count, miss_count;

    l3_cache_assoc_if #(.ADDR_W(32), .WORD_W(32), .LINE_W(128)) bus ();

    l3_cache_assoc #(
        .ADDR_W(32), .WORD_W(32), .WORDS(4), .SETS(4), .WAYS(2), .CNT_W(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_if     (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit           m_valid [4][TW];
    bit           m_dirty [4][TW];
    logic [25:0]  m_tag   [4][TW];
    logic [127:0] m_data  [4][TW];
    int           lru_order [4][TW];
    int           m_hits, m_misses;
    logic [127:0] model_mem [logic [31:0]];
    logic [127:0] phys_mem  [logic [31:0]];
    memx_t        expq[$];
    done_t        expd[$];

    bit          chk_en = 1'b0;
    bit          busy = 1'b0;
    bit          ack_given = 1'b0;
    int          ack_cnt = 0;
    int          ack_dly = 1;
    int          wb_seen = 0;
    logic [31:0] last_wb_addr, last_rf_addr;
    logic [127:0] last_wb_data;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [127:0] pat(logic [31:0] a);
        return {a ^ 32'h1111_0000, a ^ 32'h2222_0000,
                a ^ 32'h3333_0000, a ^ 32'h4444_0000};
    endfunction

    function automatic logic [127:0] model_get(logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return pat(a);
    endfunction

    function automatic logic [127:0] phys_get(logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return pat(a);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < TW; i++) begin
                m_valid[s][i]   = 1'b0;
                m_dirty[s][i]   = 1'b0;
                lru_order[s][i] = i;
            end
        end
        m_hits   = 0;
        m_misses = 0;
        expq.delete();
        expd.delete();
    endfunction

    // Move a way to the most-recently-used end of its set's ordering.
    function automatic void touch(int s, int way);
        int p = 0;
        for (int i = 0; i < TW; i++) if (lru_order[s][i] == way) p = i;
        for (int i = p; i > 0; i--) lru_order[s][i] = lru_order[s][i-1];
        lru_order[s][0] = way;
    endfunction

    task automatic model_access(input bit w, input logic [31:0] a,
                                input logic [31:0] d, input int dly,
                                output int lat, output logic [31:0] rd);
        int s, way, off;
        logic [25:0] t;
        logic [31:0] la;
        memx_t x;
        done_t dn;
        s   = int'(a[5:4]);
        off = int'(a[3:2]);
        t   = a[31:6];
        way = -1;
        for (int i = 0; i < TW; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == t) way = i;
        end
        if (way >= 0) begin
            m_hits++;
            lat = 1;
        end else begin
            m_misses++;
            way = lru_order[s][TW-1];
            for (int i = TW - 1; i >= 0; i--) if (!m_valid[s][i]) way = i;
            lat = dly + 2;
            if (m_valid[s][way] && m_dirty[s][way]) begin
                la = {m_tag[s][way], a[5:4], 4'h0};
                x.we = 1'b1; x.addr = la; x.data = m_data[s][way];
                expq.push_back(x);
                model_mem[la] = m_data[s][way];
                lat = 2 * dly + 2;
            end
            la = {t, a[5:4], 4'h0};
            x.we = 1'b0; x.addr = la; x.data = '0;
            expq.push_back(x);
            m_data[s][way]  = model_get(la);
            m_tag[s][way]   = t;
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
        end
        touch(s, way);
        rd = m_data[s][way][127-32*off -: 32];
        if (w) begin
            m_data[s][way][127-32*off -: 32] = d;
            m_dirty[s][way] = 1'b1;
        end
        dn.w = w; dn.rd = rd;
        expd.push_back(dn);
    endtask

    // Compare process plus memory responder; checks run before the responder acts.
    always @(negedge clk) begin
        if (ack_given) begin
            ack_given   = 1'b0;
            bus.mem_ack = 1'b0;
            ack_cnt     = 0;
        end
        if (chk_en) begin
            chk("cpu_ready", bus.cpu_ready, !busy);
            if (bus.cpu_done) begin
                if (expd.size() == 0) begin
                    chk("cpu_done_unexpected", 1, 0);
                end else begin
                    if (!expd[0].w) chk("cpu_rdata", bus.cpu_rdata, expd[0].rd);
                    void'(expd.pop_front());
                end
                busy = 1'b0;
            end else begin
                chk("cpu_rdata_idle", bus.cpu_rdata, 0);
            end
            if (bus.mem_req) begin
                if (expq.size() == 0) begin
                    chk("mem_req_unexpected", 1, 0);
                end else begin
                    chk("mem_we", bus.mem_we, expq[0].we);
                    chk("mem_addr", bus.mem_addr, expq[0].addr);
                    if (expq[0].we) chk("mem_wdata", bus.mem_wdata, expq[0].data);
                end
            end
        end
        if (bus.mem_req && !ack_given) begin
            ack_cnt++;
            if (ack_cnt >= ack_dly) begin
                bus.mem_ack = 1'b1;
                ack_given   = 1'b1;
                if (bus.mem_we) begin
                    phys_mem[bus.mem_addr] = bus.mem_wdata;
                    wb_seen++;
                    last_wb_addr = bus.mem_addr;
                    last_wb_data = bus.mem_wdata;
                end else begin
                    bus.mem_rdata = phys_get(bus.mem_addr);
                    last_rf_addr  = bus.mem_addr;
                end
                if (chk_en && expq.size() != 0) void'(expq.pop_front());
            end
        end
    end

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int dly, output logic [31:0] got);
        int lat, n;
        bit seen;
        logic [31:0] erd;
        ack_dly = dly;
        model_access(w, a, d, dly, lat, erd);
        bus.cpu_valid = 1'b1;
        bus.cpu_write = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0;
        busy = 1'b1;
        n = 0; seen = 1'b0; got = '0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.cpu_done) begin
                seen = 1'b1;
                got  = bus.cpu_rdata;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        else chk("latency", n, lat);
        @(posedge clk); #1;
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int wb0;
        bus.cpu_valid = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        model_mem[32'h10] = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        phys_mem[32'h10]  = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_ready", bus.cpu_ready, 1);
        chk("rst_done", bus.cpu_done, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        chk_en = 1'b1;

        do_req(0, 32'h10, 0, 3, got);
        chk("t1_rf_addr_lit", last_rf_addr, 32'h10);
        chk("t1_rdata_lit", got, 32'hA0);
        do_req(0, 32'h1C, 0, 3, got);
        chk("t1_hit_rdata_lit", got, 32'hA3);
        chk("t1_hits_lit", hit_count, 1);
        chk("t1_misses_lit", miss_count, 1);

        do_req(1, 32'h14, 32'hDEADBEEF, 2, got);
        do_req(0, 32'h14, 0, 2, got);
        chk("t2_rdata_lit", got, 32'hDEADBEEF);
        chk("t2_hits_lit", hit_count, 3);

        wb0 = wb_seen;
        do_req(0, 32'h10, 0, 2, got);
        do_req(0, 32'h50, 0, 2, got);
        do_req(0, 32'h10, 0, 1, got);
        do_req(0, 32'h90, 0, 4, got);
        chk("t3_rf90_lit", last_rf_addr, 32'h90);
        do_req(0, 32'h10, 0, 1, got);
        chk("t3_still_hit_lit", got, 32'hA0);
        do_req(0, 32'h50, 0, 2, got);
        chk("t3_rf50_lit", last_rf_addr, 32'h50);
        chk("t3_no_wb_lit", wb_seen, wb0);

        do_req(1, 32'h54, 32'h12345678, 2, got);
        do_req(0, 32'h10, 0, 2, got);
        do_req(0, 32'h90, 0, 2, got);
        chk("t4_wb_addr_lit", last_wb_addr, 32'h50);
        chk("t4_wb_word1_lit", last_wb_data[95:64], 32'h12345678);
        chk("t4_rf_addr_lit", last_rf_addr, 32'h90);
        do_req(0, 32'h54, 0, 3, got);
        chk("t4_reload_lit", got, 32'h12345678);
        chk("t4_wb10_lit", last_wb_addr, 32'h10);

        fork
            do_req(0, 32'hA0, 0, 25, got);
            begin
                repeat (3) @(posedge clk);
                #1;
                for (int i = 0; i < 20; i++) begin
                    bus.cpu_valid = (i % 2 == 0);
                    bus.cpu_write = 1'b1;
                    bus.cpu_addr  = 32'hB0 + 32'(i * 4);
                    bus.cpu_wdata = 32'hBAD0_0000 + 32'(i);
                    @(posedge clk); #1;
                end
                bus.cpu_valid = 1'b0;
            end
        join

        chk_en = 1'b0;
        ack_dly = 1000;
        bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 32'hC0;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_req_before_lit", bus.mem_req, 1);
        chk("t6_addr_before_lit", bus.mem_addr, 32'hC0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t6_mem_req_lit", bus.mem_req, 0);
        chk("t6_ready_lit", bus.cpu_ready, 1);
        chk("t6_hits_lit", hit_count, 0);
        chk("t6_misses_lit", miss_count, 0);
        model_reset();
        busy = 1'b0; bus.mem_ack = 1'b0; ack_given = 1'b0; ack_cnt = 0;
        chk_en = 1'b1;
        do_req(0, 32'h1C, 0, 2, got);
        chk("t6_rf_addr_lit", last_rf_addr, 32'h10);
        chk("t6_rdata_lit", got, 32'hA3);
        chk("t6_misses_after_lit", miss_count, 1);
        chk("t6_hits_after_lit", hit_count, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
